spi_device_core: RTL and testbench
==================================

Name: spi_device_core

Overview:
SPI target (slave) peripheral. It is the far end of the existing SPI host: it receives SCLK, SS and MOSI from an external master and drives MISO. All pins are oversampled in the single system clock domain. It provides the same TL-UL-style register port (addr/wdata/be/we/re, registered rdata) as the host, and raises RX/TX interrupts on word boundaries.

Parameters:
SYNC_STAGES, 2, flops in each input-pin synchronizer (min 2)
MAX_LEN, 32, maximum character length in bits; sets shift-register width

Ports:
clk_i  in  1  system clock; must be >= 8x SCLK frequency
rst_i  in  1  synchronous reset, active-high
addr_i  in  8  register byte address; bits [6:0] decoded
wdata_i  in  32  write data
rdata_o  out  32  read data, registered, valid 1 cycle after re_i
be_i  in  4  byte enables
we_i  in  1  write strobe
re_i  in  1  read strobe
error_o  out  1  tied 0
intr_rx_o  out  1  1-cycle pulse: word received
intr_tx_o  out  1  1-cycle pulse: TX buffer consumed (free for refill)
ss_ni  in  1  target select, active-low, asynchronous pin
sclk_i  in  1  serial clock from master, asynchronous pin
sd_i  in  1  MOSI, asynchronous pin
sd_o  out  1  MISO data
sd_oe  out  1  MISO output enable

Behaviour:
- Reset: all registers, rdata_o, intr_*, sd_o and sd_oe are 0. FSM is IDLE. Synchronizers are set to ss=1, sclk=0, sd=0.
- Register map (writes only when we_i & ~re_i):
  - 0x00 TXDATA (W): writes load tx_buf, honouring be_i, and set tx_valid.
  - 0x04 RXDATA (R): returns rx_buf. A read clears rx_valid.
  - 0x08 CTRL (RW): [4:0] len (0 means 32), [5] cpol, [6] cpha, [7] lsb-first, [8] ie, [9] en. Writes are ignored while state != IDLE.
  - 0x0C STATUS: [0] rx_valid, [1] tx_valid, [2] rx_overrun, [3] tx_underrun, [4] frame_err, [5] busy. Bits [4:2] are write-1-to-clear.
- Unmapped reads return 0. rdata_o is 1-cycle registered.
- Pin path: SYNC_STAGES flops feed one edge-detect flop. A pin change is acted on SYNC_STAGES+1 clk_i cycles later. sd_o updates the cycle after that.
- Leading edge = SCLK leaving its cpol idle level; trailing edge = SCLK returning to it.
  - cpha=0: sample on leading edge; drive the next bit on trailing edge.
  - cpha=1: drive on leading edge; sample on trailing edge.
- Bit order: lsb=0 shifts MSB of the len-bit field first; lsb=1 shifts bit 0 first.
- FSM states: IDLE, LOAD, ACTIVE.
  - IDLE -> LOAD: on synchronized ss falling edge while en=1. If en=0, the pins are ignored and sd_oe stays 0.
  - LOAD (1 cycle):
    - If tx_valid: shift_tx <= tx_buf; clear tx_valid; pulse intr_tx_o (if ie).
    - Else: shift_tx <= 0; set tx_underrun.
    - bit_cnt <= 0.
    - cpha=0: drive first bit onto sd_o.
    - Next state: ACTIVE.
  - ACTIVE, per sample edge: shift in sd_i; bit_cnt++.
  - ACTIVE, when bit_cnt reaches len (a sample edge with bit_cnt == len-1):
    - rx_buf <= assembled word, right-aligned, upper bits zero.
    - If rx_valid was already 1, set rx_overrun (rx_buf is still overwritten).
    - Set rx_valid; pulse intr_rx_o (if ie).
    - Go to LOAD for the next word while ss stays low (back-to-back words).
  - Any state, synchronized ss rising edge: return to IDLE next cycle. Discard the partial word. Set frame_err if 0 < bit_cnt < len. rx_buf is not updated.
- sd_oe = 1 exactly while state != IDLE and en=1. sd_o holds the current output bit, and is 0 in IDLE.
- A RXDATA read coinciding with a word completion: the completion wins; rx_valid stays 1 and there is no overrun.
- A TXDATA write in the same cycle as LOAD: LOAD consumes the old tx_buf; the new write sets tx_valid for the next word.
- busy = (state != IDLE).

Decomposition:
- spi_device_pkg holds:
  - register offsets (TXDATA_OFF=0x00, RXDATA_OFF=0x04, CTRL_OFF=0x08, STATUS_OFF=0x0C);
  - CTRL and STATUS bit-index constants;
  - the FSM state enum (IDLE, LOAD, ACTIVE).
- Sub-module spi_device_sync: parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs. Three instances: ss, sclk, sd.

Test Plan:
- Mode 0, len=8, msb-first, tx_buf=0xA5; master sends 0x3C at clk_i/16 -> MISO carries 0xA5; RXDATA=0x3C; rx_valid=1; one intr_rx_o pulse.
- Mode 3 (cpol=1, cpha=1), lsb=1, len=16, tx=0x1234, master sends 0xBEEF -> MISO bit stream LSB-first 0x1234; RXDATA=0x0000BEEF.
- Two back-to-back 8-bit words with ss held low and no RXDATA read between them -> rx_overrun=1; RXDATA = second word. The second word has no TXDATA refill -> tx_underrun=1 and MISO sends 0x00.
- ss deasserted after 5 of 8 bits -> frame_err=1; rx_valid unchanged; FSM IDLE; sd_oe=0. Writing 0x10 to STATUS clears frame_err.
- len=0 (32-bit), tx=0xDEADBEEF, master sends 0xCAFEF00D -> full 32-bit exchange on both lines correct.
- rst_i asserted mid-word -> next cycle: all outputs 0, STATUS=0, FSM IDLE. A following full transfer succeeds.

Source files
------------

// File: rtl/spi_device_pkg.sv
// Shared definitions for the SPI target core: register offsets, CTRL/STATUS bit
// positions and the serial FSM state type.
package spi_device_pkg;

  localparam logic [6:0] TXDATA_OFF = 7'h00;
  localparam logic [6:0] RXDATA_OFF = 7'h04;
  localparam logic [6:0] CTRL_OFF   = 7'h08;
  localparam logic [6:0] STATUS_OFF = 7'h0C;

  localparam int CTRL_CPOL = 5;
  localparam int CTRL_CPHA = 6;
  localparam int CTRL_LSB  = 7;
  localparam int CTRL_IE   = 8;
  localparam int CTRL_EN   = 9;

  localparam int STAT_RX_VALID    = 0;
  localparam int STAT_TX_VALID    = 1;
  localparam int STAT_RX_OVERRUN  = 2;
  localparam int STAT_TX_UNDERRUN = 3;
  localparam int STAT_FRAME_ERR   = 4;
  localparam int STAT_BUSY        = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // A programmed length of zero selects the full 32-bit character.
  function automatic logic [5:0] eff_len(input logic [4:0] len);
    if (len == 5'd0) begin
      return 6'd32;
    end else begin
      return {1'b0, len};
    end
  endfunction

endpackage

// File: rtl/spi_device_sync.sv
// Input-pin synchronizer: SYNC_STAGES flops followed by one edge-detect flop,
// giving the synchronized level plus single-cycle rise/fall pulses.
module spi_device_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Next values of the synchronizer chain and edge-detect flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Chain registers; reset to the pin's idle level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_device_core.sv
// SPI target peripheral: oversampled SS/SCLK/MOSI pins, configurable mode,
// length and bit order, with a small register port and RX/TX word interrupts.
module spi_device_core
  import spi_device_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_LEN     = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic [3:0]  be_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic        error_o,
  output logic        intr_rx_o,
  output logic        intr_tx_o,
  input  logic        ss_ni,
  input  logic        sclk_i,
  input  logic        sd_i,
  output logic        sd_o,
  output logic        sd_oe
);

  localparam int IW = $clog2(MAX_LEN);

  state_e               state_q, state_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [MAX_LEN-1:0]   shift_tx_q, shift_tx_d;
  logic [MAX_LEN-1:0]   shift_rx_q, shift_rx_d;
  logic                 sd_o_q, sd_o_d;
  logic                 sd_oe_q, sd_oe_d;
  logic [31:0]          tx_buf_q, tx_buf_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [31:0]          rx_buf_q, rx_buf_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_overrun_q, rx_overrun_d;
  logic                 tx_underrun_q, tx_underrun_d;
  logic                 frame_err_q, frame_err_d;
  logic [4:0]           len_q, len_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic                 lsb_q, lsb_d;
  logic                 ie_q, ie_d;
  logic                 en_q, en_d;
  logic                 intr_rx_q, intr_rx_d;
  logic                 intr_tx_q, intr_tx_d;
  logic [31:0]          rdata_q, rdata_d;

  logic ss_lvl_s, ss_rise_s, ss_fall_s;
  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic sd_s, sd_rise_s, sd_fall_s;
  logic unused_s;

  logic [5:0]         len_eff_s;
  logic               lead_s, trail_s, sample_s, drive_s, done_s;
  logic               wr_s, rd_rx_s;
  logic [IW-1:0]      tx_idx_s, first_idx_s, cnt_idx_s;
  logic [MAX_LEN-1:0] rx_next_s, load_word_s;

  spi_device_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (ss_ni),
    .q_o (ss_lvl_s), .rise_o (ss_rise_s), .fall_o (ss_fall_s)
  );

  spi_device_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (sclk_i),
    .q_o (sclk_lvl_s), .rise_o (sclk_rise_s), .fall_o (sclk_fall_s)
  );

  spi_device_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sd (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (sd_i),
    .q_o (sd_s), .rise_o (sd_rise_s), .fall_o (sd_fall_s)
  );

  assign unused_s = ^{addr_i[7], sclk_lvl_s, sd_rise_s, sd_fall_s};

  // Edges are classified against the idle level; sampling is ignored once SS has risen.
  assign len_eff_s   = eff_len(len_q);
  assign lead_s      = cpol_q ? sclk_fall_s : sclk_rise_s;
  assign trail_s     = cpol_q ? sclk_rise_s : sclk_fall_s;
  assign sample_s    = (cpha_q ? trail_s : lead_s) & ~ss_lvl_s;
  assign drive_s     = cpha_q ? lead_s : trail_s;
  assign done_s      = (state_q == ACTIVE) && sample_s && (bit_cnt_q == len_eff_s - 6'd1);
  assign wr_s        = we_i & ~re_i;
  assign rd_rx_s     = re_i && (addr_i[6:0] == RXDATA_OFF);
  assign cnt_idx_s   = IW'(bit_cnt_q);
  assign tx_idx_s    = lsb_q ? IW'(bit_cnt_q) : IW'(len_eff_s - 6'd1 - bit_cnt_q);
  assign first_idx_s = lsb_q ? {IW{1'b0}} : IW'(len_eff_s - 6'd1);
  assign load_word_s = tx_valid_q ? MAX_LEN'(tx_buf_q) : {MAX_LEN{1'b0}};

  // Receive word with the current MOSI bit merged in, right-aligned.
  always_comb begin
    rx_next_s = shift_rx_q;
    if (lsb_q) begin
      rx_next_s[cnt_idx_s] = sd_s;
    end else begin
      rx_next_s = {shift_rx_q[MAX_LEN-2:0], sd_s};
    end
  end

  // Register-side clears, then the serial FSM, then TXDATA writes, so that
  // hardware sets beat software clears and a new TX write survives LOAD.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_tx_d    = shift_tx_q;
    shift_rx_d    = shift_rx_q;
    sd_o_d        = sd_o_q;
    tx_buf_d      = tx_buf_q;
    tx_valid_d    = tx_valid_q;
    rx_buf_d      = rx_buf_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = tx_underrun_q;
    frame_err_d   = frame_err_q;
    len_d         = len_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    lsb_d         = lsb_q;
    ie_d          = ie_q;
    en_d          = en_q;
    intr_rx_d     = 1'b0;
    intr_tx_d     = 1'b0;

    if (rd_rx_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    if (wr_s && addr_i[6:0] == STATUS_OFF && be_i[0]) begin
      rx_overrun_d  = rx_overrun_q  & ~wdata_i[STAT_RX_OVERRUN];
      tx_underrun_d = tx_underrun_q & ~wdata_i[STAT_TX_UNDERRUN];
      frame_err_d   = frame_err_q   & ~wdata_i[STAT_FRAME_ERR];
    end else begin
      frame_err_d = frame_err_q;
    end

    if (wr_s && addr_i[6:0] == CTRL_OFF && state_q == IDLE) begin
      if (be_i[0]) begin
        {lsb_d, cpha_d, cpol_d, len_d} = wdata_i[7:0];
      end else begin
        len_d = len_q;
      end
      if (be_i[1]) begin
        {en_d, ie_d} = wdata_i[CTRL_EN:CTRL_IE];
      end else begin
        en_d = en_q;
      end
    end else begin
      len_d = len_q;
    end

    if (ss_rise_s && state_q != IDLE) begin
      state_d   = IDLE;
      bit_cnt_d = 6'd0;
      if (bit_cnt_q != 6'd0 && bit_cnt_q < len_eff_s) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = frame_err_d;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall_s && en_q) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          if (tx_valid_q) begin
            shift_tx_d = load_word_s;
            tx_valid_d = 1'b0;
            intr_tx_d  = ie_q;
          end else begin
            shift_tx_d    = {MAX_LEN{1'b0}};
            tx_underrun_d = 1'b1;
          end
          shift_rx_d = {MAX_LEN{1'b0}};
          bit_cnt_d  = 6'd0;
          if (!cpha_q) begin
            sd_o_d = load_word_s[first_idx_s];
          end else begin
            sd_o_d = sd_o_q;
          end
          state_d = ACTIVE;
        end
        ACTIVE: begin
          if (sample_s) begin
            shift_rx_d = rx_next_s;
            bit_cnt_d  = bit_cnt_q + 6'd1;
            if (done_s) begin
              rx_buf_d     = 32'(rx_next_s);
              rx_overrun_d = rx_overrun_d | (rx_valid_q & ~rd_rx_s);
              rx_valid_d   = 1'b1;
              intr_rx_d    = ie_q;
              state_d      = LOAD;
            end else begin
              state_d = ACTIVE;
            end
          end else if (drive_s) begin
            sd_o_d = shift_tx_q[tx_idx_s];
          end else begin
            state_d = ACTIVE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (wr_s && addr_i[6:0] == TXDATA_OFF) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          tx_buf_d[8*b +: 8] = wdata_i[8*b +: 8];
        end else begin
          tx_buf_d[8*b +: 8] = tx_buf_q[8*b +: 8];
        end
      end
      tx_valid_d = 1'b1;
    end else begin
      tx_buf_d = tx_buf_q;
    end

    if (state_d == IDLE) begin
      sd_o_d = 1'b0;
    end else begin
      sd_o_d = sd_o_d;
    end
    sd_oe_d = (state_d != IDLE) && en_q;
  end

  // Registered read data; unmapped offsets and idle cycles return zero.
  always_comb begin
    rdata_d = 32'd0;
    if (re_i) begin
      case (addr_i[6:0])
        RXDATA_OFF: rdata_d = rx_buf_q;
        CTRL_OFF:   rdata_d = {22'd0, en_q, ie_q, lsb_q, cpha_q, cpol_q, len_q};
        STATUS_OFF: rdata_d = {26'd0, (state_q != IDLE), frame_err_q, tx_underrun_q,
                               rx_overrun_q, tx_valid_q, rx_valid_q};
        default:    rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // State and register file.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 6'd0;
      shift_tx_q    <= '0;
      shift_rx_q    <= '0;
      sd_o_q        <= 1'b0;
      sd_oe_q       <= 1'b0;
      tx_buf_q      <= 32'd0;
      tx_valid_q    <= 1'b0;
      rx_buf_q      <= 32'd0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
      len_q         <= 5'd0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      lsb_q         <= 1'b0;
      ie_q          <= 1'b0;
      en_q          <= 1'b0;
      intr_rx_q     <= 1'b0;
      intr_tx_q     <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_tx_q    <= shift_tx_d;
      shift_rx_q    <= shift_rx_d;
      sd_o_q        <= sd_o_d;
      sd_oe_q       <= sd_oe_d;
      tx_buf_q      <= tx_buf_d;
      tx_valid_q    <= tx_valid_d;
      rx_buf_q      <= rx_buf_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
      len_q         <= len_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      lsb_q         <= lsb_d;
      ie_q          <= ie_d;
      en_q          <= en_d;
      intr_rx_q     <= intr_rx_d;
      intr_tx_q     <= intr_tx_d;
      rdata_q       <= rdata_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign error_o   = 1'b0;
  assign intr_rx_o = intr_rx_q;
  assign intr_tx_o = intr_tx_q;
  assign sd_o      = sd_o_q;
  assign sd_oe     = sd_oe_q;

endmodule

// File: tb/tb_spi_device_core.sv
// Directed bench for spi_device_core: a behavioural SPI master at clk/16 plus
// register accesses, with hand-computed expectations for each scenario.
module tb_spi_device_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        we, re;
  logic        error;
  logic        intr_rx, intr_tx;
  logic        ss_n, sclk, mosi;
  logic        sd_o, sd_oe;

  int tests = 0;
  int fails = 0;
  int rx_pulses = 0;
  int tx_pulses = 0;
  logic cpol_m = 1'b0;
  logic cpha_m = 1'b0;
  logic lsb_m  = 1'b0;

  spi_device_core #(.SYNC_STAGES(2), .MAX_LEN(32)) dut (
    .clk_i (clk), .rst_i (rst), .addr_i (addr), .wdata_i (wdata), .rdata_o (rdata),
    .be_i (be), .we_i (we), .re_i (re), .error_o (error),
    .intr_rx_o (intr_rx), .intr_tx_o (intr_tx),
    .ss_ni (ss_n), .sclk_i (sclk), .sd_i (mosi), .sd_o (sd_o), .sd_oe (sd_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (intr_rx) rx_pulses++;
    if (intr_tx) tx_pulses++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    addr = a; wdata = d; be = b; we = 1'b1;
    @(negedge clk);
    we = 1'b0; be = 4'h0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic spi_word(input logic [31:0] mosi_w, input int n, output logic [31:0] miso_w);
    int idx;
    miso_w = 32'd0;
    for (int k = 0; k < n; k++) begin
      idx = lsb_m ? k : n - 1 - k;
      if (!cpha_m) begin
        mosi = mosi_w[idx];
        half();
        miso_w[idx] = sd_o;
        sclk = ~cpol_m;
        half();
        sclk = cpol_m;
      end else begin
        sclk = ~cpol_m;
        mosi = mosi_w[idx];
        half();
        miso_w[idx] = sd_o;
        sclk = cpol_m;
        half();
      end
    end
  endtask

  task automatic ss_begin();
    ss_n = 1'b0;
    half();
  endtask

  task automatic ss_end();
    half();
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, miso1, miso2;
    int rx0, tx0;
    rst = 1'b1; addr = 8'h00; wdata = 32'd0; be = 4'h0; we = 1'b0; re = 1'b0;
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_sd_o", {31'd0, sd_o}, 32'd0);
    check("rst_sd_oe", {31'd0, sd_oe}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reg_read(8'h0C, rd); check("rst_status", rd, 32'h0);
    reg_read(8'h08, rd); check("rst_ctrl", rd, 32'h0);
    reg_read(8'h04, rd); check("rst_rxdata", rd, 32'h0);

    // Mode 0, len 8, msb-first
    cpol_m = 1'b0; cpha_m = 1'b0; lsb_m = 1'b0;
    reg_write(8'h08, 32'h0000_0308, 4'hF);
    reg_read(8'h08, rd); check("m0_ctrl", rd, 32'h308);
    reg_write(8'h00, 32'h0000_00A5, 4'hF);
    reg_read(8'h0C, rd); check("m0_status_txv", rd, 32'h02);
    rx0 = rx_pulses; tx0 = tx_pulses;
    ss_begin();
    check("m0_sd_oe", {31'd0, sd_oe}, 32'd1);
    reg_read(8'h0C, rd); check("m0_status_busy", rd, 32'h20);
    reg_write(8'h08, 32'h0000_0000, 4'hF);
    reg_read(8'h08, rd); check("m0_ctrl_locked", rd, 32'h308);
    spi_word(32'h3C, 8, miso1);
    ss_end();
    check("m0_miso", miso1, 32'hA5);
    check("m0_intr_rx", 32'(rx_pulses - rx0), 32'd1);
    check("m0_intr_tx", 32'(tx_pulses - tx0), 32'd1);
    check("m0_sd_oe_idle", {31'd0, sd_oe}, 32'd0);
    reg_read(8'h0C, rd); check("m0_status", rd, 32'h09);
    reg_read(8'h04, rd); check("m0_rxdata", rd, 32'h3C);
    reg_write(8'h0C, 32'h1C, 4'hF);
    reg_read(8'h0C, rd); check("m0_status_clr", rd, 32'h00);
    reg_read(8'h10, rd); check("unmapped", rd, 32'h0);

    // Mode 3, len 16, lsb-first
    reg_write(8'h08, 32'h0000_03F0, 4'hF);
    cpol_m = 1'b1; cpha_m = 1'b1; lsb_m = 1'b1;
    sclk = 1'b1;
    repeat (10) @(negedge clk);
    reg_write(8'h00, 32'h0000_1234, 4'hF);
    rx0 = rx_pulses;
    ss_begin();
    spi_word(32'hBEEF, 16, miso1);
    ss_end();
    check("m3_miso", miso1, 32'h1234);
    check("m3_intr_rx", 32'(rx_pulses - rx0), 32'd1);
    reg_read(8'h0C, rd); check("m3_status", rd, 32'h09);
    reg_read(8'h04, rd); check("m3_rxdata", rd, 32'h0000BEEF);
    reg_write(8'h0C, 32'h1C, 4'hF);

    // Back-to-back words, overrun and underrun
    reg_write(8'h08, 32'h0000_0308, 4'hF);
    cpol_m = 1'b0; cpha_m = 1'b0; lsb_m = 1'b0;
    sclk = 1'b0;
    repeat (10) @(negedge clk);
    reg_write(8'h00, 32'h0000_005A, 4'hF);
    rx0 = rx_pulses;
    ss_begin();
    spi_word(32'h11, 8, miso1);
    spi_word(32'h22, 8, miso2);
    ss_end();
    check("b2b_miso1", miso1, 32'h5A);
    check("b2b_miso2", miso2, 32'h00);
    check("b2b_intr_rx", 32'(rx_pulses - rx0), 32'd2);
    reg_read(8'h0C, rd); check("b2b_status", rd, 32'h0D);
    reg_read(8'h04, rd); check("b2b_rxdata", rd, 32'h22);
    reg_write(8'h0C, 32'h1C, 4'hF);
    reg_read(8'h0C, rd); check("b2b_status_clr", rd, 32'h00);

    // Frame error after 5 of 8 bits
    reg_write(8'h00, 32'h0000_00C3, 4'hF);
    ss_begin();
    spi_word(32'h1F, 5, miso1);
    ss_end();
    check("fe_sd_oe", {31'd0, sd_oe}, 32'd0);
    check("fe_sd_o", {31'd0, sd_o}, 32'd0);
    reg_read(8'h0C, rd); check("fe_status", rd, 32'h10);
    reg_read(8'h04, rd); check("fe_rxdata_kept", rd, 32'h22);
    reg_write(8'h0C, 32'h10, 4'hF);
    reg_read(8'h0C, rd); check("fe_status_clr", rd, 32'h00);

    // Full 32-bit exchange (len = 0)
    reg_write(8'h08, 32'h0000_0300, 4'hF);
    reg_write(8'h00, 32'hDEAD_BEEF, 4'hF);
    ss_begin();
    spi_word(32'hCAFE_F00D, 32, miso1);
    ss_end();
    check("l32_miso", miso1, 32'hDEADBEEF);
    reg_read(8'h0C, rd); check("l32_status", rd, 32'h09);
    reg_read(8'h04, rd); check("l32_rxdata", rd, 32'hCAFEF00D);
    reg_write(8'h0C, 32'h1C, 4'hF);

    // Reset in the middle of a word, then a clean transfer
    reg_write(8'h08, 32'h0000_0308, 4'hF);
    reg_write(8'h00, 32'h0000_0099, 4'hF);
    ss_begin();
    spi_word(32'h07, 3, miso1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_sd_o", {31'd0, sd_o}, 32'd0);
    check("mrst_sd_oe", {31'd0, sd_oe}, 32'd0);
    check("mrst_intr", {30'd0, intr_rx, intr_tx}, 32'd0);
    check("mrst_rdata", rdata, 32'd0);
    rst = 1'b0;
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (6) @(negedge clk);
    reg_read(8'h0C, rd); check("mrst_status", rd, 32'h00);
    reg_read(8'h08, rd); check("mrst_ctrl", rd, 32'h00);
    reg_write(8'h08, 32'h0000_0308, 4'hF);
    reg_write(8'h00, 32'h0000_00A5, 4'hF);
    ss_begin();
    spi_word(32'h3C, 8, miso1);
    ss_end();
    check("post_miso", miso1, 32'hA5);
    reg_read(8'h0C, rd); check("post_status", rd, 32'h09);
    reg_read(8'h04, rd); check("post_rxdata", rd, 32'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
